// File: rtl/acq_pkg.sv
// Shared state encoding for the acquisition controller FSM.
package acq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRETRIG  = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_POSTTRIG = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PRETRIG  = ST_PRETRIG,
        ARMED    = ST_ARMED,
        POSTTRIG = ST_POSTTRIG,
        DONE     = ST_DONE
    } state_t;

    function automatic logic is_capturing(state_t s);
        return (s == PRETRIG) || (s == ARMED) || (s == POSTTRIG);
    endfunction

endpackage

// File: rtl/acquisition_controller_if.sv
// Sample stream in and buffer write port out of the acquisition controller.
interface acquisition_controller_if #(
    parameter int BITS_ADC   = 8,
    parameter int ADDR_WIDTH = 12
);
    logic [BITS_ADC-1:0]   trigger_source_in;
    logic                  trigger_source_rdy;
    logic                  buf_we;
    logic [ADDR_WIDTH-1:0] buf_waddr;

    modport master (
        input  trigger_source_in,
        input  trigger_source_rdy,
        output buf_we,
        output buf_waddr
    );

    modport slave (
        output trigger_source_in,
        output trigger_source_rdy,
        input  buf_we,
        input  buf_waddr
    );
endinterface

// File: rtl/edge_detector.sv
// Rising threshold-crossing detector: remembers the previous loaded sample and
// flags an unsigned prev < threshold <= current transition.
module edge_detector #(
    parameter int BITS_ADC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [BITS_ADC-1:0] sample,
    input  logic [BITS_ADC-1:0] threshold,
    output logic                crossing
);
    logic [BITS_ADC-1:0] prev;
    logic                prev_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (load) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    // Without a valid previous sample the first load only primes the history.
    assign crossing = load && prev_valid && (prev < threshold) && (sample >= threshold);
endmodule

// File: rtl/acquisition_controller.sv
// Oscilloscope-style acquisition sequencer: pre-trigger fill, armed wait for a
// rising crossing, post-trigger fill, then hold results until restarted.
module acquisition_controller
    import acq_pkg::*;
#(
    parameter int BITS_ADC   = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [BITS_ADC-1:0]     trigger_value_in,
    input  logic [ADDR_WIDTH-1:0]   pretrig_len,
    input  logic [ADDR_WIDTH-1:0]   num_samples,
    acquisition_controller_if.master bus,
    output logic [ADDR_WIDTH-1:0]   trigger_addr,
    output logic                    acq_busy,
    output logic                    acq_done,
    output logic                    triggered
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] post_len;
    logic                  rdy;
    logic                  start_ok;
    logic                  arm_load;
    logic                  crossing;

    assign rdy      = bus.trigger_source_rdy;
    assign cnt_inc  = cnt + ADDR_WIDTH'(1);
    assign addr_inc = addr + ADDR_WIDTH'(1);
    assign start_ok = start && !stop && ((state == IDLE) || (state == DONE));
    assign arm_load = (state == ARMED) && rdy;

    // The trigger sample itself is always a post-trigger sample, so at least one.
    assign post_len = (num_samples > pretrig_len) ? (num_samples - pretrig_len)
                                                  : ADDR_WIDTH'(1);

    edge_detector #(
        .BITS_ADC(BITS_ADC)
    ) u_edge_detector (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .load     (arm_load),
        .sample   (bus.trigger_source_in),
        .threshold(trigger_value_in),
        .crossing (crossing)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            cnt           <= '0;
            bus.buf_we    <= 1'b0;
            bus.buf_waddr <= '0;
            trigger_addr  <= '0;
            acq_busy      <= 1'b0;
            acq_done      <= 1'b0;
            triggered     <= 1'b0;
        end else begin
            bus.buf_we <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                acq_busy  <= 1'b0;
                acq_done  <= 1'b0;
                triggered <= 1'b0;
            end else begin
                // Every accepted sample is written at the running address, which wraps freely.
                if (is_capturing(state) && rdy &&
                    !(state == PRETRIG && pretrig_len == '0) &&
                    !(state == POSTTRIG && cnt >= post_len)) begin
                    bus.buf_we    <= 1'b1;
                    bus.buf_waddr <= addr;
                    addr          <= addr_inc;
                end
                unique case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state     <= PRETRIG;
                            addr      <= '0;
                            cnt       <= '0;
                            acq_busy  <= 1'b1;
                            acq_done  <= 1'b0;
                            triggered <= 1'b0;
                        end
                    end
                    PRETRIG: begin
                        if (pretrig_len == '0) begin
                            state <= ARMED;
                            cnt   <= '0;
                        end else if (rdy) begin
                            if (cnt_inc == pretrig_len) begin
                                state <= ARMED;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    ARMED: begin
                        if (crossing) begin
                            state        <= POSTTRIG;
                            trigger_addr <= addr;
                            cnt          <= ADDR_WIDTH'(1);
                            triggered    <= 1'b1;
                        end
                    end
                    POSTTRIG: begin
                        if (cnt >= post_len) begin
                            state    <= DONE;
                            acq_busy <= 1'b0;
                            acq_done <= 1'b1;
                        end else if (rdy) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == post_len) begin
                                state    <= DONE;
                                acq_busy <= 1'b0;
                                acq_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_acquisition_controller.sv
// Directed bench for acquisition_controller with hand-computed expectations.
module tb_acquisition_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  trigger_value_in = 8'h80;
    logic [11:0] pretrig_len = 12'd4;
    logic [11:0] num_samples = 12'd10;
    logic [11:0] trigger_addr;
    logic        acq_busy;
    logic        acq_done;
    logic        triggered;

    int checks = 0;
    int failures = 0;
    int wr;

    acquisition_controller_if #(.BITS_ADC(8), .ADDR_WIDTH(12)) bus ();

    acquisition_controller #(
        .BITS_ADC  (8),
        .ADDR_WIDTH(12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stop            (stop),
        .trigger_value_in(trigger_value_in),
        .pretrig_len     (pretrig_len),
        .num_samples     (num_samples),
        .bus             (bus),
        .trigger_addr    (trigger_addr),
        .acq_busy        (acq_busy),
        .acq_done        (acq_done),
        .triggered       (triggered)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] s, input logic r);
        bus.trigger_source_in  = s;
        bus.trigger_source_rdy = r;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.buf_we), 0);
        chk({tag, "_waddr"}, 32'(bus.buf_waddr), 0);
        chk({tag, "_taddr"}, 32'(trigger_addr), 0);
        chk({tag, "_busy"},  32'(acq_busy), 0);
        chk({tag, "_done"},  32'(acq_done), 0);
        chk({tag, "_trig"},  32'(triggered), 0);
    endtask

    initial begin
        bus.trigger_source_in  = 8'h00;
        bus.trigger_source_rdy = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(acq_busy), 0);

        // Ramp acquisition: pretrig 4, total 10, threshold 0x80
        start = 1'b1;
        feed(8'h00, 1'b0);
        start = 1'b0;
        chk("start_busy", 32'(acq_busy), 1);
        chk("start_we", 32'(bus.buf_we), 0);
        wr = 0;
        for (int i = 0; i < 15; i++) begin
            feed(8'(i * 16), 1'b1);
            if (bus.buf_we) wr++;
            if (i == 0 || i == 3 || i == 4 || i == 8 || i == 13) begin
                chk("ramp_we", 32'(bus.buf_we), 1);
                chk("ramp_addr", 32'(bus.buf_waddr), 32'(i));
            end
            if (i == 7) chk("ramp_not_trig", 32'(triggered), 0);
            if (i == 8) begin
                chk("ramp_trig", 32'(triggered), 1);
                chk("ramp_taddr", 32'(trigger_addr), 8);
            end
            if (i == 12) chk("ramp_not_done", 32'(acq_done), 0);
            if (i == 13) begin
                chk("ramp_done", 32'(acq_done), 1);
                chk("ramp_idle_busy", 32'(acq_busy), 0);
            end
            if (i == 14) begin
                chk("done_hold_we", 32'(bus.buf_we), 0);
                chk("done_hold_taddr", 32'(trigger_addr), 8);
                chk("done_hold_done", 32'(acq_done), 1);
            end
        end
        chk("ramp_total_writes", 32'(wr), 14);

        // Stop with simultaneous start during POSTTRIG
        start = 1'b1;
        feed(8'h00, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 10; i++) feed(8'(i * 16), 1'b1);
        chk("post_trig", 32'(triggered), 1);
        stop = 1'b1;
        start = 1'b1;
        feed(8'hA0, 1'b1);
        stop = 1'b0;
        start = 1'b0;
        chk("stop_we", 32'(bus.buf_we), 0);
        chk("stop_busy", 32'(acq_busy), 0);
        chk("stop_done", 32'(acq_done), 0);
        chk("stop_trig", 32'(triggered), 0);
        feed(8'hB0, 1'b1);
        chk("stop_idle_we", 32'(bus.buf_we), 0);

        // Zero pretrigger, zero length: single post-trigger write
        pretrig_len = 12'd0;
        num_samples = 12'd0;
        start = 1'b1;
        feed(8'h00, 1'b1);
        start = 1'b0;
        feed(8'h00, 1'b1);
        chk("z_pretrig_we", 32'(bus.buf_we), 0);
        chk("z_busy", 32'(acq_busy), 1);
        feed(8'h00, 1'b1);
        chk("z_first_we", 32'(bus.buf_we), 1);
        chk("z_first_addr", 32'(bus.buf_waddr), 0);
        chk("z_first_trig", 32'(triggered), 0);
        feed(8'h90, 1'b1);
        chk("z_trig_we", 32'(bus.buf_we), 1);
        chk("z_trig_addr", 32'(bus.buf_waddr), 1);
        chk("z_trig", 32'(triggered), 1);
        chk("z_taddr", 32'(trigger_addr), 1);
        chk("z_not_done", 32'(acq_done), 0);
        feed(8'h90, 1'b1);
        chk("z_done_we", 32'(bus.buf_we), 0);
        chk("z_done", 32'(acq_done), 1);
        feed(8'h90, 1'b1);
        chk("z_hold_we", 32'(bus.buf_we), 0);
        chk("z_hold_taddr", 32'(trigger_addr), 1);

        // Constant 0xFF source: never triggers, address wraps
        num_samples = 12'd10;
        start = 1'b1;
        feed(8'hFF, 1'b1);
        start = 1'b0;
        feed(8'hFF, 1'b1);
        wr = 0;
        for (int k = 0; k < 4098; k++) begin
            feed(8'hFF, 1'b1);
            if (bus.buf_we) wr++;
            if (k == 0 || k == 4095 || k == 4096 || k == 4097) begin
                chk("wrap_we", 32'(bus.buf_we), 1);
                chk("wrap_addr", 32'(bus.buf_waddr), 32'(k % 4096));
            end
        end
        chk("wrap_writes", 32'(wr), 4098);
        chk("wrap_no_trig", 32'(triggered), 0);
        chk("wrap_busy", 32'(acq_busy), 1);
        stop = 1'b1;
        feed(8'hFF, 1'b1);
        stop = 1'b0;
        chk("wrap_stop_busy", 32'(acq_busy), 0);

        // Reset mid-PRETRIG with rdy toggling
        pretrig_len = 12'd4;
        start = 1'b1;
        feed(8'h00, 1'b0);
        start = 1'b0;
        feed(8'h10, 1'b1);
        feed(8'h20, 1'b0);
        feed(8'h30, 1'b1);
        chk("mid_we", 32'(bus.buf_we), 1);
        chk("mid_addr", 32'(bus.buf_waddr), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        feed(8'h40, 1'b0);
        feed(8'h50, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            feed(8'(k), k[0]);
            chk("post_rst_we", 32'(bus.buf_we), 0);
        end
        chk("post_rst_busy", 32'(acq_busy), 0);
        start = 1'b1;
        feed(8'h00, 1'b0);
        start = 1'b0;
        feed(8'h11, 1'b1);
        chk("restart_we", 32'(bus.buf_we), 1);
        chk("restart_addr", 32'(bus.buf_waddr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acquisition_controller.md
ACQUISITION_CONTROLLER -- requirements
Module: acquisition_controller

Interface
REQ-001 Parameter BITS_ADC, default 8, width of trigger source and trigger value.
REQ-002 Parameter ADDR_WIDTH, default 12, sample buffer address width; buffer depth 2^ADDR_WIDTH.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse, begin acquisition.
REQ-006 stop  input  1  one-cycle pulse, abort acquisition.
REQ-007 trigger_source_in  input  BITS_ADC  selected (possibly inverted) trigger source sample.
REQ-008 trigger_value_in  input  BITS_ADC  trigger threshold.
REQ-009 trigger_source_rdy  input  1  new sample valid this cycle.
REQ-010 pretrig_len  input  ADDR_WIDTH  samples to capture before arming.
REQ-011 num_samples  input  ADDR_WIDTH  total samples per acquisition.
REQ-012 buf_we  output  1  buffer write strobe.
REQ-013 buf_waddr  output  ADDR_WIDTH  buffer write address.
REQ-014 trigger_addr  output  ADDR_WIDTH  address of the triggering sample.
REQ-015 acq_busy  output  1  high in PRETRIG, ARMED, POSTTRIG.
REQ-016 acq_done  output  1  high in DONE.
REQ-017 triggered  output  1  high in POSTTRIG and DONE.

Function
REQ-018 FSM states SHALL be IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
REQ-019 IDLE/DONE + start -> PRETRIG; write address, sample counter, prev-valid flag cleared; start ignored in other states.
REQ-020 stop in any state -> IDLE next cycle; stop wins over simultaneous start; buf_we low from that cycle.
REQ-021 In PRETRIG/ARMED/POSTTRIG, each cycle with trigger_source_rdy high SHALL produce buf_we=1 one cycle later with buf_waddr = current address; address then increments.
REQ-022 Address SHALL wrap from 2^ADDR_WIDTH-1 to 0 without stalling.
REQ-023 PRETRIG -> ARMED once pretrig_len samples written; pretrig_len=0 -> ARMED on the cycle after start, no sample written in PRETRIG.
REQ-024 ARMED: crossing SHALL be prev < trigger_value_in and current >= trigger_value_in, prev = last rdy sample; first ARMED sample only loads prev (no trigger).
REQ-025 On crossing -> POSTTRIG; trigger_addr latched with that sample's address; that sample counts as first post-trigger sample.
REQ-026 POSTTRIG -> DONE after (num_samples - pretrig_len) post-trigger samples written; if num_samples <= pretrig_len, post length SHALL be 1.
REQ-027 Rdy on a state-transition cycle SHALL be written exactly once and counted in the state being left (PRETRIG) or as trigger sample (ARMED).
REQ-028 DONE holds buf_we=0, trigger_addr and acq_done stable until start or stop.
REQ-029 Comparisons SHALL be unsigned, BITS_ADC wide.

Reset
REQ-030 rst_n low SHALL force IDLE, buf_we=0, buf_waddr=0, trigger_addr=0, acq_busy=0, acq_done=0, triggered=0, counters and prev sample 0, prev-valid clear.
REQ-031 Reset asserted mid-acquisition SHALL abort immediately with no further writes.

Structure
REQ-032 State encoding localparams and the state_t definition SHALL live in shared package acq_pkg.
REQ-033 Crossing detector (prev register + compare) SHALL be sub-module edge_detector; counters and FSM stay top-level.

Verification
REQ-034 pretrig_len=4, num_samples=10, value=0x80, ramp 0x00..0xFF step 0x10 rdy every cycle -> ARMED after addr 3, trigger on sample 0x80, 6 post writes, acq_done, total 10+ARMED writes.
REQ-035 Trigger source constant 0xFF -> no crossing, stays ARMED, writes wrap 4095->0 continuously.
REQ-036 stop during POSTTRIG with start same cycle -> IDLE next cycle, buf_we 0, acq_done 0.
REQ-037 pretrig_len=0, num_samples=0, crossing on 2nd ARMED sample -> exactly one post write, DONE, trigger_addr=1.
REQ-038 rst_n low mid-PRETRIG with rdy toggling -> all outputs 0 asynchronously, no buf_we after release until start.
